mux_arb_nx1: RTL
================

MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
REQ-001 SHALL have parameter W, default 32, data width per channel.
REQ-002 SHALL have parameter N, default 8, input channel count (2..16).
REQ-003 SHALL have localparam SW = $clog2(N), the select and channel-index width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N*W  channel k occupies bits [k*W +: W].
REQ-007 SHALL have port in_valid  input  N  per-channel valid.
REQ-008 SHALL have port in_ready  output  N  per-channel ready, combinational.
REQ-009 SHALL have port mode  input  1  0 = direct select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SW  channel index used in mode 0.
REQ-011 SHALL have port out_data  output  W  registered selected data.
REQ-012 SHALL have port out_chan  output  SW  registered index of the channel that produced out_data.
REQ-013 SHALL have port out_valid  output  1  output register holds data.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL have load_en = !out_valid || out_ready, so a full register that is being drained reloads in the same cycle.
REQ-016 SHALL, in mode 0, grant channel sel only; no grant if sel >= N.
REQ-017 SHALL, in mode 1, grant the first valid channel searching from ptr+1 upward with wrap N-1 -> 0; ptr is the last granted channel.
REQ-018 SHALL assert in_ready[g] = load_en for granted channel g, with all other in_ready bits 0.
REQ-019 SHALL treat a transfer as in_valid[g] && in_ready[g]; on a transfer, load out_data = in_data[g], load out_chan = g, and set out_valid = 1.
REQ-020 SHALL clear out_valid on out_ready with no new transfer, leaving out_data and out_chan unchanged.
REQ-021 SHALL give 1-cycle latency from input transfer to out_valid, with 1 transfer per cycle sustained under out_ready = 1.
REQ-022 SHALL hold out_data, out_chan and out_valid stable while out_valid && !out_ready, regardless of sel, mode or inputs.
REQ-023 SHALL update ptr only on a mode-1 transfer and leave it unchanged in mode 0.
REQ-024 SHALL apply a mode or sel change to the next arbitration only, never to the held output.
REQ-025 SHALL make no grant and no state change when no candidate channel is valid.

Reset
REQ-026 SHALL, with reset high at a clk edge, set out_valid = 0, out_data = 0, out_chan = 0 and ptr = N-1 (channel 0 highest priority first).
REQ-027 SHALL drive in_ready = 0 while reset is high; reset mid-transfer discards the held word.

Configuration
REQ-028 SHALL, when MUX_ARB_XFER_CNT_EN is defined, add port xfer_cnt output 32, counting input transfers, reset to 0, wrapping 0xFFFFFFFF -> 0.
REQ-029 SHALL, without MUX_ARB_XFER_CNT_EN, have no xfer_cnt port and no counter logic.

Structure
REQ-030 SHALL place the mode encoding constants (MODE_SEL = 0, MODE_RR = 1) and default W/N in package mux_arb_pkg.
REQ-031 SHALL implement round-robin search in sub-module rr_arbiter (req[N], ptr[SW] -> gnt_vld, gnt_idx[SW]), combinational.

Verification
REQ-032 SHALL check: reset; mode 0; in_data ch0..7 = 0, 1, 8, 16, 32, 64, 128, 256; all valid; sel stepped 0..7, one per cycle; out_ready = 1 -> out_data sequence 0, 1, 8, 16, 32, 64, 128, 256 one cycle after each sel, with out_chan = sel.
REQ-033 SHALL check: mode 1, all 8 valid, out_ready = 1 -> out_chan 0, 1, ..., 7, 0 on consecutive cycles.
REQ-034 SHALL check: mode 1, only ch2 and ch5 valid -> out_chan alternates 2, 5, 2; in_ready[other] = 0.
REQ-035 SHALL check: out_valid = 1 with out_data = 16, out_ready = 0 for 3 cycles while sel changes -> out_data stays 16; all in_ready = 0.
REQ-036 SHALL check: mode 0, sel = 7 with N = 5 -> no grant, out_valid stays 0.
REQ-037 SHALL check: reset asserted while out_valid = 1 -> next cycle out_valid = 0, out_data = 0, and with MUX_ARB_XFER_CNT_EN defined, xfer_cnt = 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants for the N:1 registered mux/arbiter: mode encodings and default sizing.
package mux_arb_pkg;

    localparam int DEF_W = 32;
    localparam int DEF_N = 8;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after ptr, wrapping N-1 -> 0.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int N  = DEF_N,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    logic [SW:0]   w_sum      [N];
    logic [SW-1:0] w_cand_idx [N];
    logic [N-1:0]  w_cand_req;

    // Candidate gi is the channel gi+1 steps past ptr, folded back into 0..N-1.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign w_sum[gi]      = {1'b0, ptr} + (SW+1)'(gi + 1);
            assign w_cand_idx[gi] = (w_sum[gi] >= (SW+1)'(N)) ? SW'(w_sum[gi] - (SW+1)'(N))
                                                              : SW'(w_sum[gi]);
            assign w_cand_req[gi] = req[w_cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        gnt_vld = |w_cand_req;
        gnt_idx = w_cand_idx[0];
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand_req[i]) begin
                gnt_idx = w_cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 registered mux with direct-select or round-robin arbitration and a valid/ready output stage.
// Optional transfer counter port xfer_cnt is built when MUX_ARB_XFER_CNT_EN is defined.
module mux_arb_nx1
    import mux_arb_pkg::*;
#(
    parameter  int W  = DEF_W,
    parameter  int N  = DEF_N,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_chan,
    output logic            out_valid,
    input  logic            out_ready
`ifdef MUX_ARB_XFER_CNT_EN
   ,output logic [31:0]     xfer_cnt
`endif
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic [W-1:0]  w_ch_data [N];
    logic          w_load_en;
    logic          w_sel_in_range;
    logic          w_sel_valid;
    logic          w_rr_vld;
    logic [SW-1:0] w_rr_idx;
    logic          w_gnt_vld;
    logic [SW-1:0] w_gnt_idx;
    logic          w_xfer;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // A full register being drained this cycle may accept the next word at once.
    assign w_load_en      = !r_out_valid || out_ready;
    assign w_sel_in_range = ({1'b0, sel} < (SW+1)'(N));
    assign w_sel_valid    = |(in_valid & (N'(1) << sel));

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_vld (w_rr_vld),
        .gnt_idx (w_rr_idx)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            w_gnt_vld = w_rr_vld;
            w_gnt_idx = w_rr_idx;
        end else begin
            w_gnt_vld = w_sel_in_range && w_sel_valid;
            w_gnt_idx = sel;
        end
    end

    assign w_xfer = w_gnt_vld && w_load_en && !reset;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = w_xfer && (w_gnt_idx == SW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SW'(N - 1);
        end else if (w_xfer) begin
            r_out_data  <= w_ch_data[w_gnt_idx];
            r_out_chan  <= w_gnt_idx;
            r_out_valid <= 1'b1;
            if (mode == MODE_RR) begin
                r_ptr <= w_gnt_idx;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

`ifdef MUX_ARB_XFER_CNT_EN
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_cnt <= '0;
        end else if (w_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
